// File: rtl/reg_ser_pkg.sv
// Shared types and constants for the serial register loader.
package reg_ser_pkg;

  localparam int unsigned DEF_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT    = 3'd1,
    ST_PARITY   = 3'd2,
    ST_COMMIT   = 3'd3,
    ST_WAIT_END = 3'd4
  } state_e;

endpackage

// File: rtl/reg_ser_loader_if.sv
// Serial input side and register-write output side of the loader.
interface reg_ser_loader_if
  import reg_ser_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             frame_in;
  logic             bit_valid_in;
  logic             bit_in;
  logic             r_en_out;
  logic [WIDTH-1:0] r_data_out;
  logic             busy_out;
  logic             parity_err_out;
  logic             frame_err_out;

  modport master (
    output frame_in, bit_valid_in, bit_in,
    input  r_en_out, r_data_out, busy_out, parity_err_out, frame_err_out
  );

  modport slave (
    input  frame_in, bit_valid_in, bit_in,
    output r_en_out, r_data_out, busy_out, parity_err_out, frame_err_out
  );

endinterface

// File: rtl/ser_shift_cnt.sv
// MSB-first shift register with a saturating bit counter.
module ser_shift_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             bit_in,
  output logic [WIDTH-1:0] shreg,
  output logic             last_bit
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;

  // Shift in accepted bits and count them, holding at WIDTH.
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (clr) begin
      cnt_d = '0;
    end else if (shift_en) begin
      shreg_d = {shreg_q[WIDTH-2:0], bit_in};
      if (cnt_q != CNT_W'(WIDTH)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter and shift register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // High when the next accepted bit brings the count to WIDTH.
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign shreg    = shreg_q;

endmodule

// File: rtl/reg_ser_loader.sv
// Serial-to-parallel write front end: frames, checks parity, strobes the word out.
module reg_ser_loader
  import reg_ser_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  reg_ser_loader_if.slave  bus
);

  state_e           state_q, state_d;
  logic             r_en_q, r_en_d;
  logic [WIDTH-1:0] r_data_q, r_data_d;
  logic             busy_q, busy_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;

  logic             shift_en;
  logic             clr;
  logic             last_bit;
  logic             par_ok;
  logic [WIDTH-1:0] shreg;

  assign shift_en = (state_q == ST_SHIFT) && bus.frame_in && bus.bit_valid_in;
  assign clr      = (state_q == ST_IDLE) && bus.frame_in;
  assign par_ok   = ~(^shreg ^ bus.bit_in);

  ser_shift_cnt #(.WIDTH(WIDTH)) u_shift (
    .clk      (clock),
    .rst_n    (reset_n),
    .shift_en (shift_en),
    .clr      (clr),
    .bit_in   (bus.bit_in),
    .shreg    (shreg),
    .last_bit (last_bit)
  );

  // Next state, error flags and the word captured on entry to COMMIT.
  always_comb begin
    state_d  = state_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    r_data_d = r_data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.frame_in) begin
          state_d = ST_SHIFT;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (!bus.frame_in) begin
          ferr_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.bit_valid_in && last_bit) begin
          if (PARITY_EN) begin
            state_d = ST_PARITY;
          end else begin
            // Last data bit is still in flight, so splice it in here.
            state_d  = ST_COMMIT;
            r_data_d = {shreg[WIDTH-2:0], bus.bit_in};
          end
        end
      end
      ST_PARITY: begin
        if (!bus.frame_in) begin
          ferr_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.bit_valid_in) begin
          if (par_ok) begin
            state_d  = ST_COMMIT;
            r_data_d = shreg;
          end else begin
            perr_d  = 1'b1;
            state_d = ST_WAIT_END;
          end
        end
      end
      ST_COMMIT:   state_d = ST_WAIT_END;
      ST_WAIT_END: if (!bus.frame_in) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  assign r_en_d = (state_d == ST_COMMIT);
  assign busy_d = (state_d != ST_IDLE);

  // FSM and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      r_en_q   <= 1'b0;
      r_data_q <= '0;
      busy_q   <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_en_q   <= r_en_d;
      r_data_q <= r_data_d;
      busy_q   <= busy_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  assign bus.r_en_out       = r_en_q;
  assign bus.r_data_out     = r_data_q;
  assign bus.busy_out       = busy_q;
  assign bus.parity_err_out = perr_q;
  assign bus.frame_err_out  = ferr_q;

endmodule

// File: tb/tb_reg_ser_loader.sv
// Bench for reg_ser_loader: directed table, reset abort, randomized frames vs. model.
module tb_reg_ser_loader;

  localparam int unsigned W = 16;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  reg_ser_loader_if #(.WIDTH(W)) bus0 ();
  reg_ser_loader_if #(.WIDTH(W)) bus1 ();

  reg_ser_loader #(.WIDTH(W), .PARITY_EN(1'b1)) dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  reg_ser_loader #(.WIDTH(W), .PARITY_EN(1'b0)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  typedef struct {
    logic f;
    logic v;
    logic b;
  } cyc_t;

  typedef struct {
    logic [W-1:0] word;
    logic         par;
    bit           pe;
    int           drop;
    bit           toggle;
    int           exp_idx;
    logic [W-1:0] exp_data;
    logic         exp_perr;
    logic         exp_ferr;
  } vec_t;

  cyc_t         stim_q[$];
  logic         obs_ren[$];
  logic [W-1:0] obs_data[$];
  logic [W-1:0] pre_data;
  logic [W-1:0] exp_data[2];
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic f, input logic v, input logic b);
    if (sel) begin
      bus1.frame_in = f; bus1.bit_valid_in = v; bus1.bit_in = b;
      bus0.frame_in = 1'b0; bus0.bit_valid_in = 1'b0; bus0.bit_in = 1'b0;
    end else begin
      bus0.frame_in = f; bus0.bit_valid_in = v; bus0.bit_in = b;
      bus1.frame_in = 1'b0; bus1.bit_valid_in = 1'b0; bus1.bit_in = 1'b0;
    end
  endtask

  task automatic sample(input bit sel, output logic ren, output logic [W-1:0] data,
                        output logic busy, output logic perr, output logic ferr);
    if (sel) begin
      ren = bus1.r_en_out; data = bus1.r_data_out; busy = bus1.busy_out;
      perr = bus1.parity_err_out; ferr = bus1.frame_err_out;
    end else begin
      ren = bus0.r_en_out; data = bus0.r_data_out; busy = bus0.busy_out;
      perr = bus0.parity_err_out; ferr = bus0.frame_err_out;
    end
  endtask

  // Apply the first n stimulus cycles, recording outputs #1 after each edge.
  task automatic run_stim(input bit sel, input int n);
    logic ren, busy, perr, ferr;
    logic [W-1:0] data;
    sample(sel, ren, pre_data, busy, perr, ferr);
    obs_ren.delete();
    obs_data.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      drive(sel, stim_q[i].f, stim_q[i].v, stim_q[i].b);
      @(posedge clock);
      #1;
      sample(sel, ren, data, busy, perr, ferr);
      obs_ren.push_back(ren);
      obs_data.push_back(data);
    end
  endtask

  // Start cycle (its valid bit must be ignored), data/parity bits, low-frame tail.
  task automatic build_frame(input logic [W-1:0] word, input logic par, input bit pe,
                             input int drop, input bit toggle);
    int   nbits;
    logic bv;
    stim_q.delete();
    stim_q.push_back('{f: 1'b1, v: 1'b1, b: 1'b1});
    nbits = (drop >= 0) ? drop : int'(W) + int'(pe);
    for (int k = 0; k < nbits; k++) begin
      bv = (k < int'(W)) ? word[W-1-k] : par;
      if (toggle && k > 0) stim_q.push_back('{f: 1'b1, v: 1'b0, b: ~bv});
      stim_q.push_back('{f: 1'b1, v: 1'b1, b: bv});
    end
    for (int k = 0; k < 3; k++) stim_q.push_back('{f: 1'b0, v: 1'b1, b: 1'($urandom)});
  endtask

  // Frame-level reference: find the completing valid bit, judge parity.
  task automatic model(input bit pe, output int idx, output logic [W-1:0] word,
                       output logic perr, output logic ferr);
    int   need, cnt, found;
    logic p;
    need  = int'(W) + int'(pe);
    cnt   = 0;
    found = -1;
    word  = '0;
    p     = 1'b0;
    for (int i = 1; i < stim_q.size() && stim_q[i].f; i++) begin
      if (stim_q[i].v) begin
        cnt++;
        if (cnt <= int'(W)) word = {word[W-2:0], stim_q[i].b};
        else p = stim_q[i].b;
        if (cnt == need) begin
          found = i;
          break;
        end
      end
    end
    ferr = (found < 0);
    perr = (found >= 0) && pe && (($countones(word) + int'(p)) % 2 != 0);
    idx  = (found >= 0 && !perr) ? found : -1;
  endtask

  // Compare recorded observations and final flags against expectations.
  task automatic eval_frame(input string nm, input bit sel, input int exp_idx,
                            input logic [W-1:0] edata, input logic eperr, input logic eferr);
    int   cnt, pos, bad;
    logic ren, busy, perr, ferr;
    logic [W-1:0] data, prev;
    cnt  = 0;
    pos  = -1;
    bad  = 0;
    prev = pre_data;
    foreach (obs_ren[i]) begin
      if (obs_ren[i] === 1'b1) begin
        cnt++;
        pos = i;
      end else if (obs_data[i] !== prev) begin
        bad++;
      end
      prev = obs_data[i];
    end
    check({nm, " strobe_count"}, 32'(cnt), (exp_idx >= 0) ? 32'd1 : 32'd0);
    if (exp_idx >= 0 && pos >= 0) begin
      check({nm, " strobe_cycle"}, 32'(pos), 32'(exp_idx));
      check({nm, " data_at_strobe"}, 32'(obs_data[pos]), 32'(edata));
    end
    check({nm, " data_only_on_strobe"}, 32'(bad), 32'd0);
    sample(sel, ren, data, busy, perr, ferr);
    check({nm, " final_data"}, 32'(data), 32'(edata));
    check({nm, " parity_err"}, 32'(perr), 32'(eperr));
    check({nm, " frame_err"}, 32'(ferr), 32'(eferr));
    check({nm, " busy_after"}, 32'(busy), 32'd0);
  endtask

  vec_t tbl[7];

  task automatic run_vec(input int t);
    bit sel;
    sel = !tbl[t].pe;
    build_frame(tbl[t].word, tbl[t].par, tbl[t].pe, tbl[t].drop, tbl[t].toggle);
    run_stim(sel, stim_q.size());
    check($sformatf("vec%0d busy_in_frame", t), 32'(obs_ren.size() > 0), 32'd1);
    eval_frame($sformatf("vec%0d", t), sel, tbl[t].exp_idx, tbl[t].exp_data,
               tbl[t].exp_perr, tbl[t].exp_ferr);
    exp_data[sel] = tbl[t].exp_data;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic ren, busy, perr, ferr;
    logic [W-1:0] data, mword, cword;
    int   midx, need, target, cnt, drop;
    bit   sel, pe;
    logic mperr, mferr, par;

    //                word      par   pe    drop tog  idx  data      perr  ferr
    tbl[0] = '{16'hA5C3, 1'b0, 1'b1, -1, 1'b0, 17, 16'hA5C3, 1'b0, 1'b0};
    tbl[1] = '{16'hA5C3, 1'b1, 1'b1, -1, 1'b0, -1, 16'hA5C3, 1'b1, 1'b0};
    tbl[2] = '{16'hA5C3, 1'b0, 1'b1,  7, 1'b0, -1, 16'hA5C3, 1'b0, 1'b1};
    tbl[3] = '{16'h0001, 1'b1, 1'b1, -1, 1'b0, 17, 16'h0001, 1'b0, 1'b0};
    tbl[4] = '{16'hFFFF, 1'b0, 1'b1, -1, 1'b1, 33, 16'hFFFF, 1'b0, 1'b0};
    tbl[5] = '{16'h1234, 1'b1, 1'b1, -1, 1'b0, 17, 16'h1234, 1'b0, 1'b0};
    tbl[6] = '{16'h8000, 1'b0, 1'b0, -1, 1'b0, 16, 16'h8000, 1'b0, 1'b0};

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    for (int s = 0; s < 2; s++) begin
      sample(s[0], ren, data, busy, perr, ferr);
      check($sformatf("reset%0d r_en", s), 32'(ren), 32'd0);
      check($sformatf("reset%0d data", s), 32'(data), 32'd0);
      check($sformatf("reset%0d busy", s), 32'(busy), 32'd0);
      check($sformatf("reset%0d perr", s), 32'(perr), 32'd0);
      check($sformatf("reset%0d ferr", s), 32'(ferr), 32'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    exp_data[0] = '0;
    exp_data[1] = '0;

    for (int t = 0; t < 5; t++) run_vec(t);

    // Reset in the middle of a frame after 10 data bits.
    build_frame(16'h1234, 1'b1, 1'b1, 10, 1'b0);
    run_stim(1'b0, 11);
    sample(1'b0, ren, data, busy, perr, ferr);
    check("midreset busy_before", 32'(busy), 32'd1);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    sample(1'b0, ren, data, busy, perr, ferr);
    check("midreset r_en", 32'(ren), 32'd0);
    check("midreset data", 32'(data), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset flags", 32'({perr, ferr}), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    sample(1'b0, ren, data, busy, perr, ferr);
    check("midreset no_strobe_after", 32'({ren, busy}), 32'd0);
    exp_data[0] = '0;
    exp_data[1] = '0;

    for (int t = 5; t < 7; t++) run_vec(t);

    // Randomized frames on either instance, judged by the frame-level model.
    for (int r = 0; r < 40; r++) begin
      sel   = 1'($urandom);
      pe    = !sel;
      cword = W'($urandom);
      par   = ^cword;
      if ($urandom_range(0, 3) == 0) par = ~par;
      need  = int'(W) + int'(pe);
      drop  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, need - 1)) : -1;
      target = (drop >= 0) ? drop : need;
      stim_q.delete();
      stim_q.push_back('{f: 1'b1, v: 1'($urandom), b: 1'($urandom)});
      cnt = 0;
      while (cnt < target) begin
        if ($urandom_range(0, 2) != 0) begin
          stim_q.push_back('{f: 1'b1, v: 1'b1,
                             b: (cnt < int'(W)) ? cword[W-1-cnt] : par});
          cnt++;
        end else begin
          stim_q.push_back('{f: 1'b1, v: 1'b0, b: 1'($urandom)});
        end
      end
      if (drop < 0) begin
        for (int k = 0; k < int'($urandom_range(0, 3)); k++)
          stim_q.push_back('{f: 1'b1, v: 1'($urandom), b: 1'($urandom)});
      end
      for (int k = 0; k < 3; k++)
        stim_q.push_back('{f: 1'b0, v: 1'($urandom), b: 1'($urandom)});
      model(pe, midx, mword, mperr, mferr);
      if (midx >= 0) exp_data[sel] = mword;
      run_stim(sel, stim_q.size());
      eval_frame($sformatf("rand%0d", r), sel, midx, exp_data[sel], mperr, mferr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
